// File: rtl/sar_scan_ctrl.sv
// sar_scan_ctrl: successive-approximation ADC controller with a
// channel-mask scan sequencer, continuous mode and start/abort control.
// Ports: clk, rst (sync, active-high); start, abort, scan_mask, continuous,
// comp_in in; dac_code, mux_sel, track, busy, result, result_ch,
// result_valid, pass_done out.
module sar_scan_ctrl #(
  parameter int WIDTH         = 8,
  parameter int CHANNELS      = 4,
  parameter int SAMPLE_CYCLES = 2,
  parameter int SETTLE        = 0,
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [CHANNELS-1:0] scan_mask,
  input  logic                continuous,
  input  logic                comp_in,
  output logic [WIDTH-1:0]    dac_code,
  output logic [CW-1:0]       mux_sel,
  output logic                track,
  output logic                busy,
  output logic [WIDTH-1:0]    result,
  output logic [CW-1:0]       result_ch,
  output logic                result_valid,
  output logic                pass_done
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SAMPLE = 2'd1;
  localparam logic [1:0] S_CONV   = 2'd2;

  localparam int IW   = $clog2(WIDTH);
  localparam int CMAX = (SAMPLE_CYCLES > SETTLE + 1) ?
                        SAMPLE_CYCLES : SETTLE + 1;
  localparam int CNTW = (CMAX > 1) ? $clog2(CMAX) : 1;

  localparam logic [CNTW-1:0] SMP_LAST = CNTW'(SAMPLE_CYCLES - 1);
  localparam logic [CNTW-1:0] SET_LAST = CNTW'(SETTLE);
  localparam logic [IW-1:0]   MSB      = IW'(WIDTH - 1);

  logic [1:0]          state;
  logic [CHANNELS-1:0] mask_q;
  logic [CW-1:0]       ch;
  logic [WIDTH-1:0]    code;
  logic [IW-1:0]       idx;
  logic [CNTW-1:0]     cnt;

  logic [WIDTH-1:0]    trial;
  logic [WIDTH-1:0]    decided;
  logic                nxt_found;
  logic [CW-1:0]       nxt_ch;

  function automatic logic [CW-1:0] lowest(input logic [CHANNELS-1:0] m);
    logic [CW-1:0] r;
    r = '0;
    for (int c = CHANNELS - 1; c >= 0; c--)
      if (m[c]) r = CW'(c);
    return r;
  endfunction

  // code holds only the bits already decided above idx
  assign trial   = code | (WIDTH'(1) << idx);
  assign decided = comp_in ? trial : code;

  // lowest enabled channel strictly above the current one
  always_comb begin
    nxt_found = 1'b0;
    nxt_ch    = '0;
    for (int c = CHANNELS - 1; c >= 0; c--) begin
      if (mask_q[c] && (c > int'(ch))) begin
        nxt_found = 1'b1;
        nxt_ch    = CW'(c);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      mask_q       <= '0;
      ch           <= '0;
      code         <= '0;
      idx          <= '0;
      cnt          <= '0;
      result       <= '0;
      result_ch    <= '0;
      result_valid <= 1'b0;
      pass_done    <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      pass_done    <= 1'b0;
      if (abort) begin
        state <= S_IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start && |scan_mask) begin
              mask_q <= scan_mask;
              ch     <= lowest(scan_mask);
              cnt    <= '0;
              state  <= S_SAMPLE;
            end
          end
          S_SAMPLE: begin
            if (cnt == SMP_LAST) begin
              cnt   <= '0;
              idx   <= MSB;
              code  <= '0;
              state <= S_CONV;
            end else begin
              cnt <= cnt + CNTW'(1);
            end
          end
          S_CONV: begin
            if (cnt != SET_LAST) begin
              cnt <= cnt + CNTW'(1);
            end else begin
              cnt <= '0;
              if (idx != '0) begin
                code <= decided;
                idx  <= idx - IW'(1);
              end else begin
                result       <= decided;
                result_ch    <= ch;
                result_valid <= 1'b1;
                if (nxt_found) begin
                  ch    <= nxt_ch;
                  state <= S_SAMPLE;
                end else begin
                  pass_done <= 1'b1;
                  if (continuous) begin
                    ch    <= lowest(mask_q);
                    state <= S_SAMPLE;
                  end else begin
                    state <= S_IDLE;
                  end
                end
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign dac_code = (state == S_CONV) ? trial : '0;
  assign mux_sel  = ch;
  assign track    = (state == S_SAMPLE);
  assign busy     = (state != S_IDLE);

endmodule

// File: tb/tb_sar_scan_ctrl.sv
// tb_sar_scan_ctrl: scoreboard bench for sar_scan_ctrl, default instance
// plus a WIDTH=10 / SETTLE=2 / SAMPLE_CYCLES=1 single-channel instance.
module tb_sar_scan_ctrl;

  typedef struct {
    logic [15:0] data;
    int          ch;
    logic        pd;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // instance A: defaults
  logic       start_a = 0, abort_a = 0, cont_a = 0;
  logic [3:0] mask_a = 0;
  logic       comp_a;
  logic [7:0] dac_a, res_a;
  logic [1:0] mux_a, rch_a;
  logic       track_a, busy_a, rv_a, pd_a;
  logic [7:0] vin [4];

  // instance B: WIDTH=10, SETTLE=2, SAMPLE_CYCLES=1, one channel
  logic       start_b = 0, abort_b = 0, cont_b = 0;
  logic [0:0] mask_b = 1'b1;
  logic       comp_b;
  logic [9:0] dac_b, res_b;
  logic [0:0] mux_b, rch_b;
  logic       track_b, busy_b, rv_b, pd_b;
  logic [9:0] vin_b = 10'h2AB;

  exp_t qa[$];
  exp_t qb[$];

  assign comp_a = (vin[mux_a] >= dac_a);
  assign comp_b = (vin_b >= dac_b);

  sar_scan_ctrl dut_a (
    .clk(clk), .rst(rst), .start(start_a), .abort(abort_a),
    .scan_mask(mask_a), .continuous(cont_a), .comp_in(comp_a),
    .dac_code(dac_a), .mux_sel(mux_a), .track(track_a), .busy(busy_a),
    .result(res_a), .result_ch(rch_a), .result_valid(rv_a),
    .pass_done(pd_a)
  );

  sar_scan_ctrl #(
    .WIDTH(10), .CHANNELS(1), .SAMPLE_CYCLES(1), .SETTLE(2)
  ) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .abort(abort_b),
    .scan_mask(mask_b), .continuous(cont_b), .comp_in(comp_b),
    .dac_code(dac_b), .mux_sel(mux_b), .track(track_b), .busy(busy_b),
    .result(res_b), .result_ch(rch_b), .result_valid(rv_b),
    .pass_done(pd_b)
  );

  // monitors: compare every result pulse against the scoreboard
  always @(negedge clk) begin
    if (rv_a === 1'b1) begin
      exp_t e;
      checks++;
      if (qa.size() == 0) begin
        errors++;
        $display("FAIL a_unexpected: result=%0h ch=%0d cyc=%0d, required no result",
                 res_a, rch_a, cyc);
      end else begin
        e = qa.pop_front();
        if (res_a !== e.data[7:0] || rch_a !== e.ch[1:0] ||
            pd_a !== e.pd || cyc != e.due) begin
          errors++;
          $display("FAIL a_result: got %0h ch%0d pd%0b cyc%0d, required %0h ch%0d pd%0b cyc%0d",
                   res_a, rch_a, pd_a, cyc, e.data[7:0], e.ch, e.pd, e.due);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rv_b === 1'b1) begin
      exp_t e;
      checks++;
      if (qb.size() == 0) begin
        errors++;
        $display("FAIL b_unexpected: result=%0h cyc=%0d, required no result",
                 res_b, cyc);
      end else begin
        e = qb.pop_front();
        if (res_b !== e.data[9:0] || rch_b !== e.ch[0:0] ||
            pd_b !== e.pd || cyc != e.due) begin
          errors++;
          $display("FAIL b_result: got %0h pd%0b cyc%0d, required %0h pd%0b cyc%0d",
                   res_b, pd_b, cyc, e.data[9:0], e.pd, e.due);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) tick(1);
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic push_a(input logic [15:0] d, input int ch,
                        input logic pd, input int due);
    exp_t e;
    e.data = d; e.ch = ch; e.pd = pd; e.due = due;
    qa.push_back(e);
  endtask

  task automatic go_a(output int t);
    start_a = 1'b1;
    tick(1);
    start_a = 1'b0;
    t = cyc;
  endtask

  // single-channel conversion on ch0, optional trial-code walk check
  task automatic run_one(input logic [7:0] v, input logic [63:0] seq,
                         input bit chk_seq);
    int t;
    vin[0] = v;
    mask_a = 4'b0001;
    go_a(t);
    push_a({8'h00, v}, 0, 1'b1, t + 10);
    chk("track_in_sample", {31'd0, track_a}, 32'd1);
    chk("dac_in_sample", {24'd0, dac_a}, 32'd0);
    if (chk_seq) begin
      for (int k = 0; k < 8; k++) begin
        wait_to(t + 2 + k);
        chk("dac_walk", {24'd0, dac_a}, {24'd0, seq[63-8*k -: 8]});
      end
    end
    wait_to(t + 10);
    chk("busy_end", {31'd0, busy_a}, 32'd0);
    tick(2);
  endtask

  initial begin
    int t;
    exp_t e;
    vin[0] = 0; vin[1] = 0; vin[2] = 0; vin[3] = 0;
    tick(3);
    rst = 1'b0;
    chk("rst_dac", {24'd0, dac_a}, 32'd0);
    chk("rst_busy", {31'd0, busy_a}, 32'd0);
    chk("rst_result", {24'd0, res_a}, 32'd0);
    chk("rst_rv", {31'd0, rv_a}, 32'd0);
    chk("rst_track", {31'd0, track_a}, 32'd0);

    // instance B: 10-bit, 3-cycle trial hold, result at T+32
    start_b = 1'b1;
    tick(1);
    start_b = 1'b0;
    t = cyc;
    e.data = 16'h02AB; e.ch = 0; e.pd = 1'b1; e.due = t + 31;
    qb.push_back(e);
    wait_to(t + 1);
    chk("b_dac_t1", {22'd0, dac_b}, 32'h200);
    wait_to(t + 3);
    chk("b_dac_t3", {22'd0, dac_b}, 32'h200);
    wait_to(t + 4);
    chk("b_dac_t4", {22'd0, dac_b}, 32'h300);
    wait_to(t + 6);
    chk("b_dac_t6", {22'd0, dac_b}, 32'h300);
    wait_to(t + 7);
    chk("b_dac_t7", {22'd0, dac_b}, 32'h280);
    wait_to(t + 31);
    chk("b_busy_end", {31'd0, busy_b}, 32'd0);
    tick(2);

    // single channel, mid-scale and extremes
    run_one(8'hA5, 64'h80C0A0B0A8A4A6A5, 1'b1);
    run_one(8'h00, 64'h0, 1'b0);
    run_one(8'hFF, 64'h80C0E0F0F8FCFEFF, 1'b1);

    // two-channel scan
    vin[1] = 8'h3C;
    vin[3] = 8'hC3;
    mask_a = 4'b1010;
    go_a(t);
    push_a(16'h3C, 1, 1'b0, t + 10);
    push_a(16'hC3, 3, 1'b1, t + 20);
    chk("scan_mux_first", {30'd0, mux_a}, 32'd1);
    wait_to(t + 9);
    chk("scan_track_conv", {31'd0, track_a}, 32'd0);
    wait_to(t + 10);
    chk("scan_track_t11", {31'd0, track_a}, 32'd1);
    chk("scan_mux_next", {30'd0, mux_a}, 32'd3);
    wait_to(t + 11);
    chk("scan_track_t12", {31'd0, track_a}, 32'd1);
    wait_to(t + 12);
    chk("scan_track_t13", {31'd0, track_a}, 32'd0);
    wait_to(t + 20);
    chk("scan_busy_end", {31'd0, busy_a}, 32'd0);
    tick(2);

    // continuous, dropped during the third conversion
    vin[0] = 8'h5A;
    mask_a = 4'b0001;
    cont_a = 1'b1;
    go_a(t);
    push_a(16'h5A, 0, 1'b1, t + 10);
    push_a(16'h5A, 0, 1'b1, t + 20);
    push_a(16'h5A, 0, 1'b1, t + 30);
    wait_to(t + 25);
    cont_a = 1'b0;
    wait_to(t + 30);
    chk("cont_busy_end", {31'd0, busy_a}, 32'd0);
    tick(12);

    // start while busy is ignored
    vin[0] = 8'h33;
    go_a(t);
    push_a(16'h33, 0, 1'b1, t + 10);
    wait_to(t + 4);
    start_a = 1'b1;
    mask_a = 4'b1111;
    tick(1);
    start_a = 1'b0;
    mask_a = 4'b0001;
    wait_to(t + 10);
    chk("rebusy_busy_end", {31'd0, busy_a}, 32'd0);
    chk("rebusy_result", {24'd0, res_a}, 32'h33);
    tick(2);

    // abort during bit 4
    vin[0] = 8'h77;
    go_a(t);
    wait_to(t + 5);
    chk("abort_bit4_dac", {24'd0, dac_a}, 32'h70);
    abort_a = 1'b1;
    tick(1);
    abort_a = 1'b0;
    chk("abort_busy", {31'd0, busy_a}, 32'd0);
    chk("abort_track", {31'd0, track_a}, 32'd0);
    chk("abort_dac", {24'd0, dac_a}, 32'd0);
    chk("abort_result", {24'd0, res_a}, 32'h33);
    tick(12);

    // abort wins over start
    start_a = 1'b1;
    abort_a = 1'b1;
    tick(1);
    start_a = 1'b0;
    abort_a = 1'b0;
    chk("abort_prio_busy", {31'd0, busy_a}, 32'd0);
    tick(12);

    // start with empty mask
    mask_a = 4'b0000;
    start_a = 1'b1;
    tick(1);
    start_a = 1'b0;
    chk("mask0_busy", {31'd0, busy_a}, 32'd0);
    tick(2);

    // reset mid-conversion on ch2
    vin[2] = 8'hF0;
    mask_a = 4'b0100;
    go_a(t);
    wait_to(t + 5);
    chk("pre_rst_mux", {30'd0, mux_a}, 32'd2);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("mrst_dac", {24'd0, dac_a}, 32'd0);
    chk("mrst_mux", {30'd0, mux_a}, 32'd0);
    chk("mrst_busy", {31'd0, busy_a}, 32'd0);
    chk("mrst_track", {31'd0, track_a}, 32'd0);
    chk("mrst_result", {24'd0, res_a}, 32'd0);
    chk("mrst_rch", {30'd0, rch_a}, 32'd0);
    chk("mrst_rv", {31'd0, rv_a}, 32'd0);
    chk("mrst_pd", {31'd0, pd_a}, 32'd0);
    tick(15);

    chk("a_queue_drained", qa.size(), 32'd0);
    chk("b_queue_drained", qb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sar_scan_ctrl.md
# sar_scan_ctrl

Parametrised successive-approximation ADC controller with a multi-channel scan sequencer. It drives the capacitive or resistive DAC trial code and the analog input-mux select, samples the external comparator once per bit, and emits a tagged result per channel. It extends the fixed 8-bit single-channel SAR with these additions:
- configurable resolution, sample time and per-bit settle time;
- channel-mask scanning with continuous mode;
- a start/abort handshake.

## Interface
Parameters:
- WIDTH, 8, conversion resolution in bits (≥2)
- CHANNELS, 4, number of mux inputs (≥1); CW = max(1, $clog2(CHANNELS))
- SAMPLE_CYCLES, 2, track-phase length in clocks (≥1)
- SETTLE, 0, extra wait clocks per bit before the comparator is sampled (≥0)

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- start  in  1  begin a scan pass (accepted only in IDLE)
- abort  in  1  terminate any activity, return to IDLE
- scan_mask  in  CHANNELS  enabled channels, latched at start
- continuous  in  1  repeat passes while high (read live)
- comp_in  in  1  comparator: 1 = Vin ≥ DAC, so keep the trial bit
- dac_code  out  WIDTH  trial code to the DAC
- mux_sel  out  CW  analog channel select
- track  out  1  sample/hold in track mode
- busy  out  1  high in any state except IDLE
- result  out  WIDTH  last completed conversion
- result_ch  out  CW  channel of result
- result_valid  out  1  one-cycle pulse, result/result_ch new
- pass_done  out  1  one-cycle pulse, coincident with result_valid of the last enabled channel of a pass

## Operation
- States: IDLE, SAMPLE, CONVERT.
- IDLE → SAMPLE when start=1 and scan_mask≠0.
  - Latch the mask.
  - mux_sel = lowest set bit.
  - If start=1 with scan_mask=0, stay in IDLE with no effect.
  - start outside IDLE is ignored.
- SAMPLE: track=1 and dac_code=0 for SAMPLE_CYCLES clocks, then go to CONVERT with bit index i=WIDTH-1.
- CONVERT: for each i from WIDTH-1 down to 0:
  - dac_code = accumulated code | (1<<i), held for SETTLE+1 clocks.
  - On the last of those clocks, sample comp_in: 0 clears bit i, 1 keeps it.
  - mux_sel is held throughout; track=0.
- After the bit-0 decision:
  - Register result, result_ch and result_valid=1.
  - If an enabled channel higher than the current one exists in the latched mask, go to SAMPLE on that channel.
  - Otherwise pulse pass_done. Then, if continuous=1, go to SAMPLE on the lowest enabled channel; else go to IDLE.
- abort=1 in any state: next state IDLE, with dac_code=0, track=0, busy=0, no result_valid and result unchanged. abort has priority over start in the same cycle.
- Reset values: dac_code=0, mux_sel=0, track=0, busy=0, result=0, result_ch=0, result_valid=0, pass_done=0, state IDLE.
- Reset mid-conversion discards the partial code.

## Timing
- start is sampled at edge T.
  - SAMPLE occupies cycles T+1 … T+SAMPLE_CYCLES.
  - CONVERT occupies the next WIDTH·(SETTLE+1) cycles.
  - result_valid is high in cycle T+1+SAMPLE_CYCLES+WIDTH·(SETTLE+1). Defaults: T+11.
- Per-channel period inside a pass or in continuous mode: SAMPLE_CYCLES+WIDTH·(SETTLE+1) clocks (default 10). There are no gap cycles; result_valid overlaps the first SAMPLE cycle of the next channel.
- comp_in is registered on the decision edge. The new dac_code appears the cycle after.
- busy deasserts in the same cycle result_valid/pass_done pulse when returning to IDLE. start is accepted again from that cycle's edge.
- continuous is evaluated only at end of pass. Deasserting it mid-pass finishes the current pass.

## Test plan
Comparator model: comp_in = (vin[mux_sel] ≥ dac_code).
- Single channel, defaults: scan_mask=0001, vin0=0xA5, start pulse at T.
  - dac_code sequence 80,C0,A0,B0,A8,A4,A6,A5.
  - result=0xA5, result_ch=0, result_valid and pass_done at T+11, busy=0.
- Extremes: vin=0x00 → 0x00; vin=0xFF → 0xFF.
  - dac_code for 0xFF walks 80,C0,E0,F0,F8,FC,FE,FF.
- Scan: scan_mask=1010, vin1=0x3C, vin3=0xC3.
  - ch1 result 0x3C at T+11 with pass_done=0.
  - ch3 result 0xC3 at T+21 with pass_done=1.
  - track high in T+11,T+12.
- Continuous: scan_mask=0001, continuous=1, result every 10 cycles.
  - Drop continuous mid-conversion: exactly one more result, then IDLE.
- Abort/ignore:
  - abort during bit 4: IDLE next cycle, no result_valid, result retains its previous value.
  - start with scan_mask=0: busy stays 0.
  - start while busy: no restart, timing unchanged.
  - rst mid-conversion: all outputs 0 next cycle.
- Parameters WIDTH=10, SETTLE=2, SAMPLE_CYCLES=1, vin=0x2AB.
  - Each trial code held 3 cycles.
  - result=0x2AB at T+32.
